i2c_regfile_ctrl: RTL and testbench
===================================

Name: i2c_regfile_ctrl

Overview:
Register-file controller that sits behind i2c_slave and sequences its byte strobes into register accesses. The first byte written after the address is a register pointer. Later written bytes store to the register file with pointer auto-increment. Master reads are served from the pointer, again with auto-increment. A local host port shares the same register file under fixed-priority arbitration, and all control logic runs in the clk domain.

Parameters:
AW, 4, register pointer width; the register file holds 2**AW bytes.
SYNC_STAGES, 2, synchronizer depth for the strobes coming from the SCL domain (minimum 2).

Ports:
clk  in  1  system clock; must be at least 8x the SCL frequency.
rst_in  in  1  reset, asynchronous, active-high.
as_in  in  1  address strobe from the slave (as_out); SCL domain.
ws_in  in  1  write-byte strobe from the slave (ws_out); SCL domain.
rs_in  in  1  read-byte-acked strobe from the slave (rs_out); SCL domain.
slv_dat  in  8  received byte from the slave (dat_out).
rd_dat  out  8  byte the slave transmits next; drives the slave's dat_in.
host_req  in  1  host access request; held high until granted.
host_we  in  1  host write enable; 1 = write, 0 = read.
host_addr  in  AW  host register address.
host_wdata  in  8  host write data.
host_gnt  out  1  one-clk pulse; marks the cycle the host access completes.
host_rdata  out  8  host read data; valid while host_gnt=1, then held.
wr_irq  out  1  one-clk pulse each time I2C writes a register.
wr_addr  out  AW  address of the last I2C register write; held between writes.

Behaviour:
- Reset (asynchronous, rst_in=1):
  - all registers 0: regs[*], ptr, rd_dat, host_rdata, wr_addr, synchronizer flops;
  - host_gnt=0, wr_irq=0, state=IDLE.
  - Reset mid-transfer abandons the transfer. No I2C strobe event is generated from synchronizer contents after reset release.
- Strobe capture:
  - each of as_in, ws_in and rs_in passes through SYNC_STAGES flops, then a rising-edge detector producing a one-clk event (ev_as, ev_ws, ev_rs).
  - latency from strobe rise to event is SYNC_STAGES+1 clk.
  - slv_dat is sampled only in the event cycle; it is stable for about one SCL period after the strobe rises.
- State machine: states IDLE, PTR, WDAT, RDAT.
  - ev_as in any state: if slv_dat[0]=0 (master write) go to PTR; if slv_dat[0]=1 (master read) go to RDAT. ptr is unchanged.
  - PTR, ev_ws: ptr <= slv_dat[AW-1:0] (upper bits ignored); go to WDAT.
  - WDAT, ev_ws: regs[ptr] <= slv_dat; wr_addr <= ptr; wr_irq=1 for one clk; ptr <= ptr+1.
  - RDAT, ev_rs: ptr <= ptr+1.
  - ev_ws in IDLE or RDAT, and ev_rs in IDLE, PTR or WDAT: ignored.
  - ev_as has precedence over ev_ws and ev_rs in the same clk.
- Pointer arithmetic: modulo 2**AW; ptr at 2**AW-1 increments to 0.
- rd_dat: registered copy of regs[ptr], updated every clk.
  - reflects pointer changes and writes from either side one clk later.
  - stable well before the slave loads it at the next SCL low phase.
- Arbitration (fixed priority, I2C first):
  - a host access is performed in any clk without an I2C register write (WDAT ev_ws).
  - in an I2C-write clk, host_gnt stays 0 and the host request stalls one clk.
  - host write: regs[host_addr] <= host_wdata, host_gnt=1.
  - host read: host_rdata <= regs[host_addr], registered together with host_gnt=1.
  - with host_req held high, grants repeat: at most one grant every other clk; host_gnt is 0 for the clk after each grant.
  - the host must drop host_req or change its request in the clk after host_gnt.
- A host write and an I2C write can never complete in the same clk, so the result is defined by order: the later write wins.

Test Plan:
- Pointer then data: strobe as with slv_dat=0x76, ws with 0x05, ws with 0xA1, ws with 0xB2 -> regs[5]=0xA1, regs[6]=0xB2; wr_irq pulses twice; wr_addr=6; ptr=7.
- Read with increment: regs[2..3]=0x11,0x22; write pointer 0x02; as with 0x77 -> rd_dat=0x11; one rs -> rd_dat=0x22 within 2 clk of ev_rs.
- Wrap-around (AW=4): pointer 0x1F is masked to 0x0F; writing 0xC0 then 0xC1 -> regs[15]=0xC0, regs[0]=0xC1, ptr=1.
- Collision: host_req write addr 3 data 0x55 held high, aligned with a WDAT ev_ws to ptr 3 data 0x66 -> host_gnt delayed one clk; final regs[3]=0x55.
- Host read back: host read addr 6 after test 1 -> host_gnt pulse with host_rdata=0xB2 in the same cycle.
- Reset mid-transfer: assert rst_in after the pointer byte, with a strobe still in the synchronizer -> all outputs 0, state IDLE, no wr_irq after release.

Source files
------------

// File: rtl/i2c_regfile_ctrl.sv
// Register-file controller behind an I2C slave. The slave's byte strobes are
// synchronised into the clk domain. They are then sequenced into pointer
// loads, auto-incrementing register writes and auto-incrementing register
// reads. A local host port shares the register file; the I2C side has
// priority.
module i2c_regfile_ctrl #(
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          as_in,
  input  logic          ws_in,
  input  logic          rs_in,
  input  logic [7:0]    slv_dat,
  output logic [7:0]    rd_dat,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_gnt,
  output logic [7:0]    host_rdata,
  output logic          wr_irq,
  output logic [AW-1:0] wr_addr
);

  localparam int DEPTH = 1 << AW;
  localparam int WW    = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, PTR, WDAT, RDAT} state_t;

  state_t            state;
  logic [AW-1:0]     ptr;
  logic [7:0]        regs [DEPTH];

  logic [SYNC_STAGES-1:0] as_sync, ws_sync, rs_sync;
  logic [2:0]        strobe_prev;
  logic              ev_as, ev_ws, ev_rs;
  logic [WW-1:0]     warm;
  logic              i2c_wr;
  logic              host_go;

  // Strobe synchronisers: plain shift chains, one per strobe.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      as_sync <= '0;
      ws_sync <= '0;
      rs_sync <= '0;
    end else begin
      as_sync <= {as_sync[SYNC_STAGES-2:0], as_in};
      ws_sync <= {ws_sync[SYNC_STAGES-2:0], ws_in};
      rs_sync <= {rs_sync[SYNC_STAGES-2:0], rs_in};
    end
  end

  // Registered rising-edge detectors. They stay muted until the synchroniser
  // chain has refilled after reset. A strobe that is already high at reset
  // release therefore updates strobe_prev without producing a false event.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      strobe_prev <= '0;
      warm        <= '0;
      ev_as       <= 1'b0;
      ev_ws       <= 1'b0;
      ev_rs       <= 1'b0;
    end else begin
      strobe_prev <= {as_sync[SYNC_STAGES-1], ws_sync[SYNC_STAGES-1], rs_sync[SYNC_STAGES-1]};
      if (warm != WARM_DONE) begin
        warm  <= warm + WW'(1);
        ev_as <= 1'b0;
        ev_ws <= 1'b0;
        ev_rs <= 1'b0;
      end else begin
        ev_as <= as_sync[SYNC_STAGES-1] & ~strobe_prev[2];
        ev_ws <= ws_sync[SYNC_STAGES-1] & ~strobe_prev[1];
        ev_rs <= rs_sync[SYNC_STAGES-1] & ~strobe_prev[0];
      end
    end
  end

  // An I2C register write takes the register-file port for this clk.
  // The host is served in any other clk, except directly after its own grant.
  assign i2c_wr  = (state == WDAT) && ev_ws && !ev_as;
  assign host_go = host_req && !host_gnt && !i2c_wr;

  // Transfer sequencer: address byte, pointer byte, then data bytes with
  // pointer auto-increment. The address strobe restarts from any state.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      ptr     <= '0;
      wr_irq  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_irq <= 1'b0;
      if (ev_as) begin
        state <= slv_dat[0] ? RDAT : PTR;
      end else begin
        case (state)
          PTR: if (ev_ws) begin
            ptr   <= slv_dat[AW-1:0];
            state <= WDAT;
          end
          WDAT: if (ev_ws) begin
            wr_addr <= ptr;
            wr_irq  <= 1'b1;
            ptr     <= ptr + AW'(1);
          end
          RDAT: if (ev_rs) begin
            ptr <= ptr + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Register file with a single write port shared by I2C and the host.
  // It also provides the registered read data for both sides.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      rd_dat     <= '0;
      host_gnt   <= 1'b0;
      host_rdata <= '0;
    end else begin
      rd_dat   <= regs[ptr];
      host_gnt <= 1'b0;
      if (i2c_wr) begin
        regs[ptr] <= slv_dat;
      end else if (host_go) begin
        host_gnt <= 1'b1;
        if (host_we) regs[host_addr] <= host_wdata;
        else         host_rdata      <= regs[host_addr];
      end
    end
  end

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// Directed bench for i2c_regfile_ctrl: I2C pointer/write/read sequences,
// pointer wrap, host/I2C collision, a host access table and mid-transfer reset.
module tb_i2c_regfile_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          as_in = 1'b0, ws_in = 1'b0, rs_in = 1'b0;
  logic [7:0]    slv_dat = '0;
  logic [7:0]    rd_dat;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic          host_gnt;
  logic [7:0]    host_rdata;
  logic          wr_irq;
  logic [AW-1:0] wr_addr;

  int checks = 0;
  int errors = 0;
  int irq_count = 0;
  int irq_base;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    exp_rdata;
  } host_vec_t;

  host_vec_t vecs [7];

  i2c_regfile_ctrl #(.AW(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_in(rst_in),
    .as_in(as_in), .ws_in(ws_in), .rs_in(rs_in), .slv_dat(slv_dat),
    .rd_dat(rd_dat),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .wr_irq(wr_irq), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_irq) irq_count++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // which: 0 = as, 1 = ws, 2 = rs
  task automatic strobe(input int which, input logic [7:0] d);
    @(posedge clk); #1;
    slv_dat = d;
    case (which)
      0: as_in = 1'b1;
      1: ws_in = 1'b1;
      default: rs_in = 1'b1;
    endcase
    repeat (4) @(posedge clk);
    #1;
    as_in = 1'b0; ws_in = 1'b0; rs_in = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic host_op(input string name, input logic we, input logic [AW-1:0] a,
                         input logic [7:0] wd, input logic check_rd, input logic [7:0] exp_rd);
    bit got = 0;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (host_gnt) begin
        got = 1;
        break;
      end
    end
    chk({name, "_gnt"}, 32'(got), 32'd1);
    if (got && check_rd) chk({name, "_rdata"}, 32'(host_rdata), 32'(exp_rd));
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  initial begin
    vecs[0] = '{we: 1'b0, addr: 4'd5,  wdata: 8'h00, exp_rdata: 8'hA1};
    vecs[1] = '{we: 1'b0, addr: 4'd6,  wdata: 8'h00, exp_rdata: 8'hB2};
    vecs[2] = '{we: 1'b1, addr: 4'd9,  wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[3] = '{we: 1'b0, addr: 4'd9,  wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[4] = '{we: 1'b1, addr: 4'd10, wdata: 8'hE7, exp_rdata: 8'h00};
    vecs[5] = '{we: 1'b0, addr: 4'd10, wdata: 8'h00, exp_rdata: 8'hE7};
    vecs[6] = '{we: 1'b0, addr: 4'd7,  wdata: 8'h00, exp_rdata: 8'h3C};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    @(negedge clk);
    chk("rst_rd_dat", 32'(rd_dat), 32'h0);
    chk("rst_host_gnt", 32'(host_gnt), 32'h0);
    chk("rst_host_rdata", 32'(host_rdata), 32'h0);
    chk("rst_wr_irq", 32'(wr_irq), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);

    // Pointer then data
    irq_base = irq_count;
    strobe(0, 8'h76);
    strobe(1, 8'h05);
    strobe(1, 8'hA1);
    strobe(1, 8'hB2);
    chk("t1_irq_count", 32'(irq_count - irq_base), 32'd2);
    chk("t1_wr_addr", 32'(wr_addr), 32'd6);
    host_op("t1_hw7", 1'b1, 4'd7, 8'h3C, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("t1_ptr7_rd_dat", 32'(rd_dat), 32'h3C);

    // Host access table
    for (int i = 0; i < 7; i++) begin
      host_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
              !vecs[i].we, vecs[i].exp_rdata);
    end

    // Read with increment and rd_dat latency
    host_op("t2_hw2", 1'b1, 4'd2, 8'h11, 1'b0, 8'h00);
    host_op("t2_hw3", 1'b1, 4'd3, 8'h22, 1'b0, 8'h00);
    strobe(0, 8'h76);
    strobe(1, 8'h02);
    strobe(0, 8'h77);
    chk("t2_rd_dat_p2", 32'(rd_dat), 32'h11);
    @(posedge clk); #1;
    rs_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 rs_in = 1'b0;
    @(negedge clk);
    chk("t2_rd_dat_before", 32'(rd_dat), 32'h11);
    @(negedge clk);
    chk("t2_rd_dat_after", 32'(rd_dat), 32'h22);
    repeat (8) @(posedge clk);

    // Wrap-around
    strobe(0, 8'h76);
    strobe(1, 8'h1F);
    strobe(1, 8'hC0);
    strobe(1, 8'hC1);
    chk("t3_wr_addr", 32'(wr_addr), 32'd0);
    host_op("t3_r15", 1'b0, 4'd15, 8'h00, 1'b1, 8'hC0);
    host_op("t3_r0", 1'b0, 4'd0, 8'h00, 1'b1, 8'hC1);
    host_op("t3_hw1", 1'b1, 4'd1, 8'h9D, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("t3_ptr1_rd_dat", 32'(rd_dat), 32'h9D);

    // Collision: host write aligned with an I2C write cycle
    strobe(0, 8'h76);
    strobe(1, 8'h03);
    @(posedge clk); #1;
    slv_dat = 8'h66; ws_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd3; host_wdata = 8'h55;
    @(negedge clk);
    @(negedge clk);
    chk("t4_irq", 32'(wr_irq), 32'd1);
    chk("t4_gnt_stall", 32'(host_gnt), 32'd0);
    @(negedge clk);
    chk("t4_gnt_late", 32'(host_gnt), 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0; ws_in = 1'b0;
    @(negedge clk);
    chk("t4_gnt_gap", 32'(host_gnt), 32'd0);
    chk("t4_wr_addr", 32'(wr_addr), 32'd3);
    repeat (8) @(posedge clk);
    host_op("t4_r3", 1'b0, 4'd3, 8'h00, 1'b1, 8'h55);

    // Reset mid-transfer with a strobe in the synchroniser
    strobe(0, 8'h76);
    strobe(1, 8'h05);
    irq_base = irq_count;
    @(posedge clk); #1;
    slv_dat = 8'h99; ws_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(negedge clk);
    chk("t5_rst_rd_dat", 32'(rd_dat), 32'h0);
    chk("t5_rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("t5_rst_host_rdata", 32'(host_rdata), 32'h0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    repeat (6) @(posedge clk);
    #1 ws_in = 1'b0;
    repeat (8) @(posedge clk);
    strobe(1, 8'h44);
    chk("t5_no_irq", 32'(irq_count - irq_base), 32'd0);
    chk("t5_rd_dat", 32'(rd_dat), 32'h0);
    host_op("t5_r5", 1'b0, 4'd5, 8'h00, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
